// File: rtl/mult_seq.sv
// Sequential shift-add multiplier for MULT/MULTU with early exit once the
// remaining multiplier bits are zero; owns the architectural HI/LO registers.
module mult_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]  state;
    logic [63:0] mcand;
    logic [31:0] mplr;
    logic [63:0] acc;
    logic        neg;
    logic [31:0] abs_a;
    logic [31:0] abs_b;

    // Handshake: start/hi_we/lo_we are accepted only on an edge where busy=0;
    // the issuer must hold off while busy=1. done marks the edge HI/LO got the product.
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    // Magnitudes; negating 0x80000000 yields 0x80000000, correct as unsigned.
    assign abs_a = (signed_op && a[31]) ? (~a + 32'd1) : a;
    assign abs_b = (signed_op && b[31]) ? (~b + 32'd1) : b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            mcand <= 64'd0;
            mplr  <= 32'd0;
            acc   <= 64'd0;
            neg   <= 1'b0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        mcand <= {32'd0, abs_a};
                        mplr  <= abs_b;
                        acc   <= 64'd0;
                        neg   <= signed_op & (a[31] ^ b[31]);
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (mplr == 32'd0) begin
                        state <= FIX;
                    end else begin
                        if (mplr[0]) acc <= acc + mcand;
                        mcand <= mcand << 1;
                        mplr  <= mplr >> 1;
                    end
                end
                FIX: begin
                    {hi, lo} <= neg ? (64'd0 - acc) : acc;
                    done     <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq.sv
// Bench for mult_seq: cycle-level reference model with a product queue,
// per-cycle comparison, directed literal cases and randomized operations.
module tb_mult_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, signed_op, hi_we, lo_we;
  logic [31:0] a, b, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;
  logic [1:0]  dbg_state;

  int tests  = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  mult_seq dut (
    .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
    .a(a), .b(b), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [63:0] exp_q[$];
  int          m_rem  = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_hi   = 32'd0;
  logic [31:0] m_lo   = 32'd0;

  function automatic logic [63:0] ref_prod(input logic s, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] xe, ye;
    xe = s ? {{32{x[31]}}, x} : {32'd0, x};
    ye = s ? {{32{y[31]}}, y} : {32'd0, y};
    return xe * ye;
  endfunction

  function automatic int ref_lat(input logic s, input logic [31:0] y);
    logic [31:0] m;
    int n;
    m = (s && y[31]) ? (32'd0 - y) : y;
    n = 0;
    for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
    return n + 2;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_rem = 0; m_done = 1'b0; m_hi = 32'd0; m_lo = 32'd0;
    end else begin
      m_done = 1'b0;
      if (m_rem == 0) begin
        if (hi_we) m_hi = wdata;
        if (lo_we) m_lo = wdata;
        if (start) begin
          exp_q.push_back(ref_prod(signed_op, a, b));
          m_rem = ref_lat(signed_op, b);
        end
      end else begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          {m_hi, m_lo} = exp_q.pop_front();
          m_done = 1'b1;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 64'(busy), 64'(m_rem != 0));
      check("done", 64'(done), 64'(m_done));
      check("hi",   64'(hi),   64'(m_hi));
      check("lo",   64'(lo),   64'(m_lo));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
  endtask

  task automatic write_reg(input logic to_hi, input logic [31:0] d);
    hi_we = to_hi; lo_we = ~to_hi; wdata = d;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  // Issues one op; garbage on the inputs while busy must be ignored.
  task automatic run_op(input logic s, input logic [31:0] x, input logic [31:0] y,
                        input logic lit, input logic [31:0] eh, input logic [31:0] el,
                        input int elat);
    int lat;
    logic got;
    signed_op = s; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; signed_op = 1'($urandom);
    lat = 0; got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (done) got = 1'b1;
      else begin
        start = 1'($urandom); hi_we = 1'($urandom); lo_we = 1'($urandom); wdata = $urandom;
      end
    end
    idle_inputs();
    if (!got) check("done_timeout", 64'(lat), 64'(elat));
    if (lit) begin
      check("lit_latency", 64'(lat), 64'(elat));
      check("lit_hi", 64'(hi), 64'(eh));
      check("lit_lo", 64'(lo), 64'(el));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] ra, rb;
    int seen;
    rst = 1'b1; idle_inputs(); signed_op = 1'b0; a = 0; b = 0; wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    run_op(1'b0, 32'd7, 32'd6, 1'b1, 32'h0, 32'h2A, 5);
    run_op(1'b1, 32'hFFFFFFFD, 32'd5, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1, 5);
    run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 32'h1, 34);
    run_op(1'b1, 32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h0, 34);
    write_reg(1'b1, 32'hDEADBEEF);
    check("mthi_deadbeef", 64'(hi), 64'hDEADBEEF);
    run_op(1'b0, 32'h12345678, 32'd0, 1'b1, 32'h0, 32'h0, 2);

    // randomized operations, back-to-back and with IDLE writes between
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 2) == 0) write_reg(1'($urandom), $urandom);
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = $urandom_range(0, 255);
        2: rb = 32'd0;
        default: rb = 32'h80000000 | $urandom_range(0, 15);
      endcase
      run_op(1'($urandom), ra, rb, 1'b0, 32'h0, 32'h0, ref_lat(1'b0, 32'd0));
    end

    // busy-period ignore and mid-operation reset
    write_reg(1'b1, 32'h1111);
    write_reg(1'b0, 32'h2222);
    signed_op = 1'b0; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h9999;
    @(posedge clk); #1;
    idle_inputs();
    check("busy_ignore_hi", 64'(hi), 64'h1111);
    check("busy_ignore_lo", 64'(lo), 64'h2222);
    check("busy_still", 64'(busy), 64'd1);
    repeat (6) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_hilo", {hi, lo}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("no_done_after_rst", 64'(seen), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
